// File: rtl/accum_ctrl.sv
// Accumulate controller around an external 5-bit add/sub stage: folds a stream
// of signed operands into a running sum and presents one result per frame.
module accum_ctrl #(
  parameter int MAX_LEN = 8,
  parameter bit SAT     = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_data,
  input  logic       in_op,
  input  logic       in_last,
  output logic [4:0] add_a,
  output logic [4:0] add_b,
  output logic       add_sub,
  input  logic [4:0] add_s,
  input  logic       add_cout,
  input  logic       add_ov,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_sum,
  output logic       out_ov,
  output logic [3:0] out_cnt,
  output logic       out_trunc
);

  localparam logic [0:0] ACC  = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  localparam logic [3:0] MAX_CNT = 4'(MAX_LEN);

  logic [0:0] state;
  logic [4:0] acc;
  logic [3:0] cnt;
  logic       ov;
  logic       trunc;

  logic       accept;
  logic [3:0] cnt_nxt;
  logic [4:0] acc_nxt;

  // Carry out is reserved on the adder interface and has no internal use.
  logic unused_cout;
  assign unused_cout = add_cout;

  // The adder sees the live operand; only its result is ever registered.
  assign add_a   = acc;
  assign add_b   = in_data;
  assign add_sub = in_op;

  assign in_ready  = (state == ACC);
  assign out_valid = (state == HOLD);
  assign out_sum   = acc;
  assign out_ov    = ov;
  assign out_cnt   = cnt;
  assign out_trunc = trunc;

  assign accept  = in_valid && in_ready;
  assign cnt_nxt = cnt + 4'd1;

  // Saturation direction comes from the accumulator sign before the update.
  always_comb begin
    acc_nxt = add_s;
    if (SAT && add_ov) begin
      acc_nxt = acc[4] ? 5'b10000 : 5'b01111;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACC;
      acc   <= 5'd0;
      cnt   <= 4'd0;
      ov    <= 1'b0;
      trunc <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            ov  <= ov | add_ov;
            if (in_last) begin
              state <= HOLD;
              trunc <= 1'b0;
            end else if (cnt_nxt == MAX_CNT) begin
              state <= HOLD;
              trunc <= 1'b1;
            end
          end
        end
        default: begin
          if (out_ready) begin
            state <= ACC;
            acc   <= 5'd0;
            cnt   <= 4'd0;
            ov    <= 1'b0;
            trunc <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accum_ctrl.sv
// Directed bench for accum_ctrl: three parameterisations share one stimulus
// stream, each with its own behavioural add/sub stage.
module tb_accum_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [4:0] in_data = 5'd0;
  logic       in_op = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // {cout, ov, sum}
  function automatic logic [6:0] add5(input logic [4:0] a, input logic [4:0] b,
                                      input logic sub);
    logic [5:0] t;
    logic [4:0] s;
    logic       o;
    if (sub) t = {1'b0, a} + {1'b0, ~b} + 6'd1;
    else     t = {1'b0, a} + {1'b0, b};
    s = t[4:0];
    if (sub) o = (a[4] != b[4]) && (s[4] != a[4]);
    else     o = (a[4] == b[4]) && (s[4] != a[4]);
    return {t[5], o, s};
  endfunction

  // Instance 0: wrap, MAX_LEN 8. Instance 1: saturate. Instance 2: MAX_LEN 4.
  logic       rdy [3];
  logic [4:0] a   [3];
  logic [4:0] b   [3];
  logic       sb  [3];
  logic [4:0] s   [3];
  logic       co  [3];
  logic       ovf [3];
  logic       vld [3];
  logic [4:0] sum [3];
  logic       oov [3];
  logic [3:0] cnt [3];
  logic       trc [3];

  for (genvar g = 0; g < 3; g++) begin : g_adder
    assign {co[g], ovf[g], s[g]} = add5(a[g], b[g], sb[g]);
  end

  accum_ctrl #(.MAX_LEN(8), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_data(in_data), .in_op(in_op), .in_last(in_last),
    .add_a(a[0]), .add_b(b[0]), .add_sub(sb[0]), .add_s(s[0]),
    .add_cout(co[0]), .add_ov(ovf[0]), .out_valid(vld[0]), .out_ready(out_ready),
    .out_sum(sum[0]), .out_ov(oov[0]), .out_cnt(cnt[0]), .out_trunc(trc[0]));

  accum_ctrl #(.MAX_LEN(8), .SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_data(in_data), .in_op(in_op), .in_last(in_last),
    .add_a(a[1]), .add_b(b[1]), .add_sub(sb[1]), .add_s(s[1]),
    .add_cout(co[1]), .add_ov(ovf[1]), .out_valid(vld[1]), .out_ready(out_ready),
    .out_sum(sum[1]), .out_ov(oov[1]), .out_cnt(cnt[1]), .out_trunc(trc[1]));

  accum_ctrl #(.MAX_LEN(4), .SAT(1'b0)) u_len (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_data(in_data), .in_op(in_op), .in_last(in_last),
    .add_a(a[2]), .add_b(b[2]), .add_sub(sb[2]), .add_s(s[2]),
    .add_cout(co[2]), .add_ov(ovf[2]), .out_valid(vld[2]), .out_ready(out_ready),
    .out_sum(sum[2]), .out_ov(oov[2]), .out_cnt(cnt[2]), .out_trunc(trc[2]));

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  // Full result bundle of instance i: {valid, sum, ov, cnt, trunc}.
  task automatic check_out(input string tag, input int i, input logic v,
                           input logic [4:0] es, input logic eo,
                           input logic [3:0] ec, input logic et);
    check({tag, ".valid"}, 8'(vld[i]), 8'(v));
    check({tag, ".sum"},   8'(sum[i]), 8'(es));
    check({tag, ".ov"},    8'(oov[i]), 8'(eo));
    check({tag, ".cnt"},   8'(cnt[i]), 8'(ec));
    check({tag, ".trunc"}, 8'(trc[i]), 8'(et));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents one operand at the falling edge; it is taken on the next rise.
  task automatic put(input logic [4:0] d, input logic op, input logic last);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_op = op; in_last = last;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst.ready", 8'(rdy[0]), 8'd1);
    check("rst.add_a", 8'(a[0]), 8'd0);
    check_out("rst", 0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0);

    // Sum frame, back to back.
    put(5'd3, 1'b0, 1'b0);
    put(5'd4, 1'b0, 1'b0);
    put(5'd5, 1'b0, 1'b1);
    check("sum.valid_pre", 8'(vld[0]), 8'd0);
    idle();
    check_out("sum", 0, 1'b1, 5'b01100, 1'b0, 4'd3, 1'b0);
    check("sum.ready_hold", 8'(rdy[0]), 8'd0);
    drain();
    check("sum.valid_post", 8'(vld[0]), 8'd0);
    check("sum.ready_post", 8'(rdy[0]), 8'd1);

    // Subtract frame, then backpressure with operands pending.
    put(5'd5, 1'b0, 1'b0);
    put(5'd7, 1'b1, 1'b1);
    @(negedge clk);
    in_data = 5'd3; in_op = 1'b1; in_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check_out("bp", 0, 1'b1, 5'b11110, 1'b0, 4'd2, 1'b0);
      check("bp.ready", 8'(rdy[0]), 8'd0);
      @(negedge clk);
    end
    drain();
    check("bp.ready_post", 8'(rdy[0]), 8'd1);
    check("bp.add_a_clear", 8'(a[0]), 8'd0);
    idle();
    check_out("bp.next", 0, 1'b1, 5'b11101, 1'b0, 4'd1, 1'b0);
    drain();

    // Wrapping overflow, sticky across a later clean operand.
    do_reset();
    put(5'd10, 1'b0, 1'b0);
    put(5'd9, 1'b0, 1'b0);
    put(5'd1, 1'b1, 1'b1);
    check("wrap.add_a", 8'(a[0]), 8'b00010011);
    idle();
    check_out("wrap", 0, 1'b1, 5'b10010, 1'b1, 4'd3, 1'b0);

    // Saturation in both directions.
    do_reset();
    put(5'd10, 1'b0, 1'b0);
    put(5'd9, 1'b0, 1'b1);
    idle();
    check_out("satp", 1, 1'b1, 5'b01111, 1'b1, 4'd2, 1'b0);
    drain();
    put(5'b10000, 1'b0, 1'b0);
    put(5'd1, 1'b1, 1'b1);
    idle();
    check_out("satn", 1, 1'b1, 5'b10000, 1'b1, 4'd2, 1'b0);

    // Length limit, with a fifth operand held until after the drain.
    do_reset();
    for (int k = 0; k < 4; k++) put(5'd1, 1'b0, 1'b0);
    @(negedge clk);
    check_out("len", 2, 1'b1, 5'b00100, 1'b0, 4'd4, 1'b1);
    check("len.ready", 8'(rdy[2]), 8'd0);
    @(negedge clk);
    check("len.sum_held", 8'(sum[2]), 8'b00100);
    in_last = 1'b1;
    drain();
    check("len.add_a_clear", 8'(a[2]), 8'd0);
    idle();
    check_out("len.fifth", 2, 1'b1, 5'b00001, 1'b0, 4'd1, 1'b0);
    drain();

    // in_last on the limiting operand wins over truncation.
    for (int k = 0; k < 3; k++) put(5'd2, 1'b0, 1'b0);
    put(5'd2, 1'b0, 1'b1);
    idle();
    check_out("lastpri", 2, 1'b1, 5'b01000, 1'b0, 4'd4, 1'b0);

    // Reset between edges discards the partial frame at once.
    do_reset();
    put(5'd7, 1'b0, 1'b0);
    put(5'd6, 1'b0, 1'b0);
    idle();
    check("mid.add_a", 8'(a[0]), 8'b00001101);
    #2 rst = 1'b1;
    #1;
    check("mid.add_a_rst", 8'(a[0]), 8'd0);
    check("mid.ready_rst", 8'(rdy[0]), 8'd1);
    check_out("mid.rst", 0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0);
    #1 rst = 1'b0;
    put(5'd2, 1'b0, 1'b1);
    idle();
    check_out("mid.next", 0, 1'b1, 5'b00010, 1'b0, 4'd1, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/accum_ctrl.md
# accum_ctrl

Sequential accumulate controller wrapped around the team's 5-bit combinational add/sub stage. It accepts a stream of signed 5-bit operands, each tagged add or subtract, over a valid/ready handshake. It drives the adder with the running accumulator and the current operand, and registers the adder's sum and overflow back into the accumulator. At the end of each frame it presents the final sum, a sticky overflow flag and the operand count on a valid/ready output port.

## Interface
- MAX_LEN, 8, maximum operands per frame (1..15); reaching it closes the frame.
- SAT, 0, 0 = two's-complement wrap on overflow; 1 = saturate to +15 / -16.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand valid.
- in_ready  out  1  controller can accept an operand.
- in_data  in  5  signed operand.
- in_op  in  1  0 = add, 1 = subtract (acc - in_data).
- in_last  in  1  last operand of the frame.
- add_a  out  5  to adder A; equals acc.
- add_b  out  5  to adder B; equals in_data.
- add_sub  out  1  to adder addsub; equals in_op.
- add_s  in  5  adder sum.
- add_cout  in  1  adder carry out (unused internally; reserved).
- add_ov  in  1  adder signed-overflow flag.
- out_valid  out  1  frame result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  5  final accumulator.
- out_ov  out  1  overflow occurred on any operand of the frame.
- out_cnt  out  4  operands accumulated in the frame.
- out_trunc  out  1  frame closed by MAX_LEN, not by in_last.

## Operation
- The FSM has two states:
  - ACC: in_ready = 1, out_valid = 0.
  - HOLD: in_ready = 0, out_valid = 1.
- Registers: acc[4:0], cnt[3:0], ov, trunc, state.
- The adder path is purely combinational within the cycle: add_a = acc, add_b = in_data, add_sub = in_op.
- Accept in ACC when in_valid & in_ready:
  - acc <= add_s (SAT = 0), or the saturated value when add_ov = 1 (SAT = 1).
  - Saturation direction follows the sign of acc before the update: acc[4] = 0 gives 01111, acc[4] = 1 gives 10000.
  - ov <= ov | add_ov; cnt <= cnt + 1.
  - If in_last = 1: go to HOLD, trunc <= 0.
  - Else if cnt + 1 == MAX_LEN: go to HOLD, trunc <= 1.
  - in_last together with cnt + 1 == MAX_LEN gives trunc = 0 (in_last has priority).
- HOLD: out_sum = acc, out_ov = ov, out_cnt = cnt, out_trunc = trunc, all held stable.
  - When out_ready = 1: go to ACC and clear acc, cnt, ov and trunc to 0.
- The first operand of every frame is combined with acc = 0, so add gives +d and sub gives -d.
- in_data, in_op and in_last are ignored whenever in_ready = 0.
- Reset mid-frame discards the partial frame entirely. No output is produced for it.

## Timing
- Reset values: state = ACC, acc = 0, cnt = 0, ov = 0, trunc = 0.
  - Therefore in_ready = 1, out_valid = 0, out_sum = 0, out_ov = 0, out_cnt = 0, out_trunc = 0.
  - add_a = 0.
- All outputs are decoded from registers only; no input feeds out_* or in_ready combinationally.
- Throughput: one operand per cycle in ACC.
- Latency: out_valid rises on the clock edge that accepts the closing operand.
- The output drain takes at least 1 cycle in HOLD. An operand can be accepted on the cycle after the out handshake.
- No simultaneous accept and drain: in_ready = 0 throughout HOLD.
- Asynchronous rst takes effect immediately regardless of clk. Release must be synchronous to clk at the system level.

## Test plan
- Sum frame: +3, +4, +5 (last), out_ready = 1 → out_sum = 01100, out_cnt = 3, out_ov = 0, out_trunc = 0. Operands on consecutive cycles; out_valid high on the cycle after the third accept.
- Subtract frame: +5, sub 7 (last) → out_sum = 11110 (-2), out_ov = 0, out_cnt = 2.
- Overflow:
  - SAT = 0: +10, +9, sub 1 (last) → out_sum = 10010, out_ov = 1 (sticky after the second operand).
  - SAT = 1: +10, +9 (last) → out_sum = 01111, out_ov = 1.
  - SAT = 1: -16, sub 1 (last) → out_sum = 10000, out_ov = 1.
- Length limit: MAX_LEN = 4, four operands of +1 with in_last = 0 → out_sum = 00100, out_cnt = 4, out_trunc = 1.
  - A fifth in_valid is not accepted until the drain completes.
- Backpressure: hold out_ready = 0 for 3 cycles in HOLD while in_valid = 1.
  - Outputs stay stable and in_ready = 0 throughout.
  - After out_ready pulses, the next frame's first operand is combined with acc = 0.
- Reset mid-frame: accept +7 and +6, then pulse rst between clock edges.
  - All outputs return to reset values immediately.
  - The next frame +2 (last) gives out_sum = 00010, out_cnt = 1, out_ov = 0.
